alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_addsub.sv | 24 ++
 rtl/alu.sv | 123 ++++++++++++
 tb/tb_alu.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and default datapath width.
package alu_pkg;

  localparam int unsigned AluWidthDefault = 6;

  typedef enum logic [2:0] {
    OP_PASS_A = 3'b000,
    OP_PASS_B = 3'b001,
    OP_NEG_A  = 3'b010,
    OP_NEG_B  = 3'b011,
    OP_LT     = 3'b100,
    OP_XNOR   = 3'b101,
    OP_ADD    = 3'b110,
    OP_SUB    = 3'b111
  } op_e;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor: sum = a + b, or a - b as a + ~b + 1 when sub_i is set.
module alu_addsub #(
  parameter int unsigned Width = 6
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             sub_i,
  output logic [Width-1:0] sum_o,
  output logic             carry_o,
  output logic             ovf_o
);

  logic [Width-1:0] b_x;
  logic [Width:0]   full;

  assign b_x  = b_i ^ {Width{sub_i}};
  assign full = {1'b0, a_i} + {1'b0, b_x} + (Width+1)'(sub_i);

  assign sum_o   = full[Width-1:0];
  assign carry_o = full[Width];
  // Signed overflow: same-sign operands producing a result of the other sign.
  assign ovf_o   = (a_i[Width-1] == b_x[Width-1]) && (sum_o[Width-1] != a_i[Width-1]);

endmodule

// File: rtl/alu.sv
// Registered ALU, latency 1, one op per cycle. Define ALU_FLAGS_EN to add the
// registered overflow and zero flag outputs.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = AluWidthDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic             f,
  input  logic             x,
  input  logic             n,
  input  logic             in_valid,
`ifdef ALU_FLAGS_EN
  output logic             overflow,
  output logic             zero,
`endif
  output logic [WIDTH-1:0] num_or_less_than,
  output logic             out_valid
);

  op_e op;
  assign op = op_e'({f, x, n});

  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_sub, add_ovf, carry_unused;

  // Negation is 0 - operand; compare is A - B; both reuse the one adder.
  always_comb begin
    add_a   = input1;
    add_b   = input2;
    add_sub = 1'b1;
    case (op)
      OP_NEG_A: begin
        add_a = '0;
        add_b = input1;
      end
      OP_NEG_B: begin
        add_a = '0;
        add_b = input2;
      end
      OP_ADD:  add_sub = 1'b0;
      default: ;
    endcase
  end

  alu_addsub #(
    .Width (WIDTH)
  ) u_addsub (
    .a_i     (add_a),
    .b_i     (add_b),
    .sub_i   (add_sub),
    .sum_o   (add_sum),
    .carry_o (carry_unused),
    .ovf_o   (add_ovf)
  );

  logic             lt;
  logic [WIDTH-1:0] res;
  logic             res_ovf;

  assign lt = add_sum[WIDTH-1] ^ add_ovf;

  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    case (op)
      OP_PASS_A: res = input1;
      OP_PASS_B: res = input2;
      OP_LT:     res = {{(WIDTH-1){1'b0}}, lt};
      OP_XNOR:   res = ~(input1 ^ input2);
      default: begin
        res     = add_sum;
        res_ovf = add_ovf;
      end
    endcase
  end

  logic [WIDTH-1:0] res_d, res_q;
  logic             valid_d, valid_q;

  assign res_d   = in_valid ? res : res_q;
  assign valid_d = in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  assign num_or_less_than = res_q;
  assign out_valid        = valid_q;

`ifdef ALU_FLAGS_EN
  logic ovf_d, ovf_q, zero_d, zero_q;

  assign ovf_d  = in_valid ? res_ovf : ovf_q;
  assign zero_d = in_valid ? (res == '0) : zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign overflow = ovf_q;
  assign zero     = zero_q;
`else
  logic res_ovf_unused;
  assign res_ovf_unused = res_ovf;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu; checks the flag outputs when ALU_FLAGS_EN is defined.
module tb_alu;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] input1 = '0;
  logic [W-1:0] input2 = '0;
  logic         f = 1'b0, x = 1'b0, n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] num_or_less_than;
  logic         out_valid;
`ifdef ALU_FLAGS_EN
  logic         overflow, zero;
`endif

  int n_cmp = 0;
  int n_err = 0;

  alu #(
    .WIDTH (W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .input1           (input1),
    .input2           (input2),
    .f                (f),
    .x                (x),
    .n                (n),
    .in_valid         (in_valid),
`ifdef ALU_FLAGS_EN
    .overflow         (overflow),
    .zero             (zero),
`endif
    .num_or_less_than (num_or_less_than),
    .out_valid        (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [W-1:0] exp_res, input logic exp_vld,
                         input logic exp_ovf, input logic exp_zero);
    chk({tag, ".result"}, 8'(num_or_less_than), 8'(exp_res));
    chk({tag, ".valid"}, 8'(out_valid), 8'(exp_vld));
`ifdef ALU_FLAGS_EN
    chk({tag, ".overflow"}, 8'(overflow), 8'(exp_ovf));
    chk({tag, ".zero"}, 8'(zero), 8'(exp_zero));
`else
    if (exp_ovf && exp_zero) $display("note: %s flags not present in this build", tag);
`endif
  endtask

  task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    {f, x, n} = op;
    input1    = a;
    input2    = b;
    in_valid  = 1'b1;
  endtask

  // Drive one op, wait one edge, check the registered result.
  task automatic step(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] exp, input logic exp_ovf);
    drive(op, a, b);
    @(posedge clk);
    #1;
    chk_out(tag, exp, 1'b1, exp_ovf, exp == '0);
  endtask

  logic [W-1:0] tp_exp [8];

  initial begin
    tp_exp = '{6'h05, 6'h0A, 6'h3B, 6'h36, 6'h01, 6'h30, 6'h0F, 6'h3B};

    #1;
    chk_out("reset", '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    step("pass_a",   3'b000, 6'b000111, 6'b000000, 6'b000111, 1'b0);
    step("pass_b",   3'b001, 6'b000000, 6'b000011, 6'b000011, 1'b0);
    step("neg_a",    3'b010, 6'b001100, 6'b000000, 6'b110100, 1'b0);
    step("neg_b",    3'b011, 6'b000000, 6'b000111, 6'b111001, 1'b0);
    step("neg_min",  3'b010, 6'b100000, 6'b000000, 6'b100000, 1'b1);
    step("lt_true",  3'b100, 6'b000011, 6'b000110, 6'b000001, 1'b0);
    step("lt_false", 3'b100, 6'b000110, 6'b111111, 6'b000000, 1'b0);
    step("lt_min",   3'b100, 6'b100000, 6'b011111, 6'b000001, 1'b0);
    step("xnor",     3'b101, 6'b010101, 6'b101101, 6'b000111, 1'b0);
    step("add",      3'b110, 6'b000001, 6'b000001, 6'b000010, 1'b0);
    step("sub",      3'b111, 6'b000111, 6'b000011, 6'b000100, 1'b0);
    step("add_ovf",  3'b110, 6'b011111, 6'b000001, 6'b100000, 1'b1);
    step("sub_ovf",  3'b111, 6'b100000, 6'b000001, 6'b011111, 1'b1);
    step("add_wrap", 3'b110, 6'b111111, 6'b000001, 6'b000000, 1'b0);

    // Idle: result and flags hold, valid drops.
    step("pre_hold", 3'b111, 6'b001001, 6'b000010, 6'b000111, 1'b0);
    in_valid = 1'b0;
    input1   = 6'b111111;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk_out("hold", 6'b000111, 1'b0, 1'b0, 1'b0);
    end

    // Eight back-to-back ops, A=5 B=10, one per opcode.
    for (int i = 0; i < 8; i++) begin
      drive(3'(i), 6'd5, 6'd10);
      @(posedge clk);
      #1;
      chk_out($sformatf("tput%0d", i), tp_exp[i], 1'b1, 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_out("tput_idle", 6'h3B, 1'b0, 1'b0, 1'b0);

    // Reset asserted mid-operation clears outputs without a clock edge.
    step("pre_rst", 3'b110, 6'b011111, 6'b000001, 6'b100000, 1'b1);
    drive(3'b000, 6'b010101, 6'b000000);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rst_async", '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    chk_out("rst_discard", '0, 1'b0, 1'b0, 1'b0);
    step("post_rst", 3'b001, 6'b000000, 6'b101010, 6'b101010, 1'b0);
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
